// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: byte FIFO with valid/ready input feeding an 8N1 serialiser.
// Defining UART_TX_PARITY_EN inserts an even-parity bit between the data bits and the stop bit.
module uart_tx_buffered #(
    parameter int CLK_PER_BIT = 868,
    parameter int ADDR_W      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              txd,
    output logic              busy,
    output logic [ADDR_W:0]   level
);

    localparam int TW = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] FULL_LEVEL = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] ZERO_LEVEL = {(ADDR_W + 1){1'b0}};
    localparam logic [ADDR_W:0] PTR_ONE    = (ADDR_W + 1)'(1);
    localparam logic [TW-1:0]   LAST_TICK  = TW'(CLK_PER_BIT - 1);
    localparam logic [TW-1:0]   TIMER_ZERO = {TW{1'b0}};
    localparam logic [TW-1:0]   TIMER_ONE  = TW'(1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;
`endif

    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction

    logic [7:0]      mem [DEPTH];
    logic [ADDR_W:0] wr_ptr;
    logic [ADDR_W:0] rd_ptr;
    logic            push;
    logic            pop;
    logic [7:0]      head;

    state_t          state;
    state_t          state_next;
    logic [TW-1:0]   timer;
    logic [TW-1:0]   timer_next;
    logic [2:0]      bit_idx;
    logic [2:0]      bit_idx_next;
    logic [7:0]      shreg;
    logic [7:0]      shreg_next;
    logic            txd_next;
    logic            tick;
`ifdef UART_TX_PARITY_EN
    logic            parity_bit;
    logic            parity_bit_next;
`endif

    // FIFO status is derived purely from the registered pointers
    always_comb begin
        level    = wr_ptr - rd_ptr;
        in_ready = (level != FULL_LEVEL);
        push     = in_valid && in_ready;
        head     = mem[rd_ptr[ADDR_W-1:0]];
        busy     = (state != S_IDLE) || (level != ZERO_LEVEL);
        tick     = (timer == LAST_TICK);
    end

    // FIFO storage; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[ADDR_W-1:0]] <= in_data;
        end
    end

    // FIFO pointers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= ZERO_LEVEL;
            rd_ptr <= ZERO_LEVEL;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // Serialiser next-state, datapath updates and next line value
    always_comb begin
        state_next   = state;
        timer_next   = timer;
        bit_idx_next = bit_idx;
        shreg_next   = shreg;
        pop          = 1'b0;
        txd_next     = 1'b1;
`ifdef UART_TX_PARITY_EN
        parity_bit_next = parity_bit;
`endif
        case (state)
            S_IDLE: begin
                if (level != ZERO_LEVEL) begin
                    pop        = 1'b1;
                    shreg_next = head;
                    timer_next = TIMER_ZERO;
                    state_next = S_START;
`ifdef UART_TX_PARITY_EN
                    parity_bit_next = even_parity(head);
`endif
                end else begin
                    state_next = S_IDLE;
                end
            end
            S_START: begin
                if (tick) begin
                    timer_next   = TIMER_ZERO;
                    bit_idx_next = 3'd0;
                    state_next   = S_DATA;
                end else begin
                    timer_next = timer + TIMER_ONE;
                end
            end
            S_DATA: begin
                if (tick) begin
                    timer_next   = TIMER_ZERO;
                    shreg_next   = shreg >> 1;
                    bit_idx_next = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_next = S_PARITY;
`else
                        state_next = S_STOP;
`endif
                    end else begin
                        state_next = S_DATA;
                    end
                end else begin
                    timer_next = timer + TIMER_ONE;
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (tick) begin
                    timer_next = TIMER_ZERO;
                    state_next = S_STOP;
                end else begin
                    timer_next = timer + TIMER_ONE;
                end
            end
`endif
            S_STOP: begin
                if (tick) begin
                    timer_next = TIMER_ZERO;
                    // Chain straight into the next start bit so frames stay contiguous
                    if (level != ZERO_LEVEL) begin
                        pop        = 1'b1;
                        shreg_next = head;
                        state_next = S_START;
`ifdef UART_TX_PARITY_EN
                        parity_bit_next = even_parity(head);
`endif
                    end else begin
                        state_next = S_IDLE;
                    end
                end else begin
                    timer_next = timer + TIMER_ONE;
                end
            end
            default: begin
                timer_next = TIMER_ZERO;
                state_next = S_IDLE;
            end
        endcase

        case (state_next)
            S_START:  txd_next = 1'b0;
            S_DATA:   txd_next = shreg_next[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: txd_next = parity_bit_next;
`endif
            default:  txd_next = 1'b1;
        endcase
    end

    // Serialiser state and the registered line driver
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            timer   <= TIMER_ZERO;
            bit_idx <= 3'd0;
            shreg   <= 8'h00;
            txd     <= 1'b1;
        end else begin
            state   <= state_next;
            timer   <= timer_next;
            bit_idx <= bit_idx_next;
            shreg   <= shreg_next;
            txd     <= txd_next;
        end
    end

`ifdef UART_TX_PARITY_EN
    // Parity of the byte currently in flight, captured at pop time
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_bit <= 1'b0;
        end else begin
            parity_bit <= parity_bit_next;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Self-checking bench for uart_tx_buffered: line waveforms are predicted from the frame format
// (start, LSB-first data, optional parity, stop) for each queued byte.
module tb_uart_tx_buffered;

    localparam int CPB   = 4;
    localparam int AW    = 2;
    localparam int DEPTH = 1 << AW;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic          txd;
    logic          busy;
    logic [AW:0]   level;

    int checks = 0;
    int errors = 0;

    logic [7:0] push_q[$];
    logic [7:0] exp_q[$];
    int         lvl_log [0:511];
    logic       rdy_log [0:511];

    always #5 clk = ~clk;

    uart_tx_buffered #(.CLK_PER_BIT(CPB), .ADDR_W(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .txd      (txd),
        .busy     (busy),
        .level    (level)
    );

    // Bit k of a frame carrying byte b
    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        else if (k <= 8) return b[k-1];
`ifdef UART_TX_PARITY_EN
        else if (k == 9) return ^b;
`endif
        else return 1'b1;
    endfunction

    // Pushes push_q one value per cycle (regardless of in_ready) from an idle DUT and checks
    // that the line carries exactly the frames of exp_q back to back, starting one cycle
    // after the first acceptance. Level and in_ready are logged per cycle (index 0 = after first edge).
    task automatic run_stream(input string name);
        int total;
        total = exp_q.size() * NB * CPB;
        fork
            begin
                for (int p = 0; p < push_q.size(); p++) begin
                    in_valid = 1'b1;
                    in_data  = push_q[p];
                    @(negedge clk);
                end
                in_valid = 1'b0;
            end
            begin
                @(negedge clk);
                lvl_log[0] = int'(level);
                rdy_log[0] = in_ready;
                for (int i = 0; i < total; i++) begin
                    logic e;
                    @(negedge clk);
                    lvl_log[i+1] = int'(level);
                    rdy_log[i+1] = in_ready;
                    e = frame_bit(exp_q[i / (NB * CPB)], (i % (NB * CPB)) / CPB);
                    checks++;
                    if (txd !== e) begin
                        errors++;
                        $display("FAIL %s txd cycle %0d: got %b want %b", name, i, txd, e);
                    end
                    checks++;
                    if (busy !== 1'b1) begin
                        errors++;
                        $display("FAIL %s busy cycle %0d: got %b want 1", name, i, busy);
                    end
                end
                @(negedge clk);
                checks++;
                if (busy !== 1'b0 || txd !== 1'b1 || level !== 0 || in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL %s end-idle: busy=%b txd=%b level=%0d in_ready=%b want 0 1 0 1",
                             name, busy, txd, level, in_ready);
                end
            end
        join
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00;
        repeat (3) @(negedge clk);
        checks++;
        if (txd !== 1'b1 || in_ready !== 1'b1 || busy !== 1'b0 || level !== 0) begin
            errors++;
            $display("FAIL reset: txd=%b in_ready=%b busy=%b level=%0d want 1 1 0 0", txd, in_ready, busy, level);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (txd !== 1'b1 || busy !== 1'b0 || level !== 0) begin
            errors++;
            $display("FAIL post-reset: txd=%b busy=%b level=%0d want 1 0 0", txd, busy, level);
        end
    endtask

    task automatic test_idle();
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            checks++;
            if (txd !== 1'b1 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL idle cycle %0d: txd=%b in_ready=%b want 1 1", i, txd, in_ready);
            end
        end
    endtask

    task automatic test_single();
        push_q = {}; exp_q = {};
        push_q.push_back(8'h55); exp_q.push_back(8'h55);
        run_stream("single");
        checks++;
        if (lvl_log[0] != 1) begin
            errors++;
            $display("FAIL single level-after-accept: got %0d want 1", lvl_log[0]);
        end
        checks++;
        if (lvl_log[1] != 0) begin
            errors++;
            $display("FAIL single level-after-pop: got %0d want 0", lvl_log[1]);
        end
    endtask

    task automatic test_back_to_back();
        int peak;
        push_q = {}; exp_q = {};
        push_q.push_back(8'h3C); push_q.push_back(8'hA3); push_q.push_back(8'h0F);
        exp_q = push_q;
        run_stream("back_to_back");
        peak = 0;
        for (int i = 0; i <= 3 * NB * CPB; i++) if (lvl_log[i] > peak) peak = lvl_log[i];
        checks++;
        if (peak != 2) begin
            errors++;
            $display("FAIL back_to_back level-peak: got %0d want 2", peak);
        end
    endtask

    task automatic test_full_fifo();
        // Pushes 0..7 on consecutive cycles; byte 0 is popped one edge after acceptance,
        // so bytes 1..4 fill the 4-deep FIFO and 5..7 are refused.
        int   exp_lvl [8] = '{1, 1, 2, 3, 4, 4, 4, 4};
        logic exp_rdy [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        push_q = {}; exp_q = {};
        for (int v = 0; v < 8; v++) push_q.push_back(8'(v));
        for (int v = 0; v < 5; v++) exp_q.push_back(8'(v));
        run_stream("full_fifo");
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (lvl_log[k] != exp_lvl[k] || rdy_log[k] !== exp_rdy[k]) begin
                errors++;
                $display("FAIL full_fifo cycle %0d: level=%0d in_ready=%b want %0d %b",
                         k, lvl_log[k], rdy_log[k], exp_lvl[k], exp_rdy[k]);
            end
        end
    endtask

    task automatic test_reset_midframe();
        in_valid = 1'b1; in_data = 8'hFF;
        @(negedge clk);
        in_data = 8'h12;
        @(negedge clk);
        in_data = 8'h34;
        @(negedge clk);
        in_valid = 1'b0;
        // Now two cycles past acceptance; advance into the middle of data bit 3
        repeat (4 * CPB) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || level !== 2) begin
            errors++;
            $display("FAIL midframe pre-reset: busy=%b level=%0d want 1 2", busy, level);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (txd !== 1'b1 || level !== 0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midframe async-reset: txd=%b level=%0d busy=%b in_ready=%b want 1 0 0 1",
                     txd, level, busy, in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (txd !== 1'b1 || level !== 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midframe after-release: txd=%b level=%0d busy=%b want 1 0 0", txd, level, busy);
        end
        push_q = {}; exp_q = {};
        push_q.push_back(8'h81); exp_q.push_back(8'h81);
        run_stream("after_reset_81");
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            int n;
            n = int'($urandom_range(1, DEPTH));
            push_q = {}; exp_q = {};
            for (int j = 0; j < n; j++) push_q.push_back(8'($urandom));
            exp_q = push_q;
            run_stream("random");
            repeat (int'($urandom_range(0, 5))) @(negedge clk);
        end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        push_q = {}; exp_q = {};
        push_q.push_back(8'h07); exp_q.push_back(8'h07);
        run_stream("parity_07");
        push_q = {}; exp_q = {};
        push_q.push_back(8'h03); exp_q.push_back(8'h03);
        run_stream("parity_03");
    endtask
`endif

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00;
        test_reset();
        test_idle();
        test_single();
        test_back_to_back();
        test_full_fifo();
        test_reset_midframe();
        test_random();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
